// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between three
// requesters (0 = loader/debug, 1 = data access, 2 = instruction fetch).
// One transaction in flight; request fields are latched at grant and the owner
// receives a one-cycle ack when the transaction completes.
//
// state | meaning
// IDLE  | no transaction; pick the next winner round-robin from ptr+1
// ISSUE | mem_en strobe for exactly one cycle
// WAIT  | down-counter spans MEM_LAT cycles of memory latency
// DONE  | ack pulse to the owner; requests ignored
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    input  logic [31:0]   wdata2,
    input  logic [3:0]    be0,
    input  logic [3:0]    be1,
    input  logic [3:0]    be2,
    output logic [2:0]    gnt,
    output logic [2:0]    ack,
    output logic [31:0]   rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Counter load value: WAIT lasts cnt+1 cycles, so load MEM_LAT-1.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    ack_q, ack_d;
    logic          mem_en_q, mem_en_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    cnt_q, cnt_d;

    logic [1:0]    ord0, ord1, ord2;
    logic [1:0]    win;
    logic          win_valid;

    function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
        case (i)
            2'd0:    bit_at = v[0];
            2'd1:    bit_at = v[1];
            2'd2:    bit_at = v[2];
            default: bit_at = 1'b0;
        endcase
    endfunction

    // Round-robin winner: search order starts just after the last owner.
    always_comb begin
        case (ptr_q)
            2'd0:    {ord0, ord1, ord2} = {2'd1, 2'd2, 2'd0};
            2'd1:    {ord0, ord1, ord2} = {2'd2, 2'd0, 2'd1};
            default: {ord0, ord1, ord2} = {2'd0, 2'd1, 2'd2};
        endcase
        win_valid = 1'b1;
        if (bit_at(req, ord0))      win = ord0;
        else if (bit_at(req, ord1)) win = ord1;
        else if (bit_at(req, ord2)) win = ord2;
        else begin
            win       = 2'd0;
            win_valid = 1'b0;
        end
    end

    // Next-state and datapath: latch fields at grant, sequence the memory access.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        ack_d    = 3'b000;
        mem_en_d = 1'b0;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d  = ST_ISSUE;
                    ptr_d    = win;
                    mem_en_d = 1'b1;
                    we_d     = bit_at(we, win);
                    case (win)
                        2'd0: begin
                            gnt_d   = 3'b001;
                            addr_d  = addr0;
                            wdata_d = wdata0;
                            be_d    = be0;
                        end
                        2'd1: begin
                            gnt_d   = 3'b010;
                            addr_d  = addr1;
                            wdata_d = wdata1;
                            be_d    = be1;
                        end
                        default: begin
                            gnt_d   = 3'b100;
                            addr_d  = addr2;
                            wdata_d = wdata2;
                            be_d    = be2;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = LAT_M1;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    ack_d   = gnt_q;
                    rdata_d = we_q ? 32'h0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // State registers; reset drops any transaction in flight without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd2;
            gnt_q    <= 3'b000;
            ack_q    <= 3'b000;
            mem_en_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            rdata_q  <= 32'h0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            mem_en_q <= mem_en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, a behavioural memory returning
// addr ^ KEY exactly MEM_LAT cycles after mem_en (junk otherwise), and an ack
// scoreboard checked by an independent monitor.
module tb_mem_arbiter;

    localparam int MEM_LAT = 2;
    localparam int AW      = 32;
    localparam logic [31:0] KEY = 32'h8C010044;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    req = '0;
    logic [2:0]    we = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic [31:0]   wdata0 = '0, wdata1 = '0, wdata2 = '0;
    logic [3:0]    be0 = '0, be1 = '0, be2 = '0;
    logic [2:0]    gnt, ack;
    logic [31:0]   rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int c0;

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    typedef struct {
        int          c;
        logic [31:0] d;
    } rd_t;
    rd_t pend[$];

    mem_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .be0(be0), .be1(be1), .be2(be2),
        .gnt(gnt), .ack(ack), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: valid data only in the cycle MEM_LAT after mem_en.
    always @(negedge clk) begin
        if (mem_en) pend.push_back('{cyc + MEM_LAT, mem_addr ^ KEY});
        while (pend.size() > 0 && pend[0].c < cyc) void'(pend.pop_front());
        if (pend.size() > 0 && pend[0].c == cyc) begin
            mem_rdata = pend[0].d;
            void'(pend.pop_front());
        end else begin
            mem_rdata = 32'hBAD00000 ^ 32'(cyc);
        end
    end

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && ack !== 3'b000) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=%b expected none (cyc %0d)", ack, cyc);
            end else begin
                e = sb.pop_front();
                check("ack_owner", 32'(ack), 32'(e.ack));
                check("ack_gnt", 32'(gnt), 32'(e.ack));
                check("ack_rdata", rdata, e.rdata);
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 3'b000;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // single read by requester 2
        do_reset();
        @(negedge clk);
        c0 = cyc;
        we = 3'b000; addr2 = 32'h40; req = 3'b100;
        sb.push_back('{3'b100, 32'h8C010004, c0 + 4});
        wait_to(c0 + 1);
        check("t1_mem_en", 32'(mem_en), 32'h1);
        check("t1_mem_addr", mem_addr, 32'h40);
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_mem_we", 32'(mem_we), 32'h0);
        wait_to(c0 + 2);
        check("t1_mem_en_once", 32'(mem_en), 32'h0);
        wait_to(c0 + 4);
        req = 3'b000;
        wait_to(c0 + 5);
        check("t1_gnt_idle", 32'(gnt), 32'h0);
        check("t1_drained", 32'(sb.size()), 32'h0);

        // all three requesting: served 0, 1, 2
        do_reset();
        @(negedge clk);
        c0 = cyc;
        addr0 = 32'h10; addr1 = 32'h20; addr2 = 32'h30; req = 3'b111;
        sb.push_back('{3'b001, 32'h8C010054, c0 + 4});
        sb.push_back('{3'b010, 32'h8C010064, c0 + 9});
        sb.push_back('{3'b100, 32'h8C010074, c0 + 14});
        wait_to(c0 + 4);  req[0] = 1'b0;
        wait_to(c0 + 9);  req[1] = 1'b0;
        wait_to(c0 + 14); req[2] = 1'b0;
        wait_to(c0 + 15);
        check("t2_drained", 32'(sb.size()), 32'h0);

        // 0 and 2 continuously requesting: alternate 0,2,0,2
        do_reset();
        @(negedge clk);
        c0 = cyc;
        addr0 = 32'h10; addr2 = 32'h30; req = 3'b101;
        sb.push_back('{3'b001, 32'h8C010054, c0 + 4});
        sb.push_back('{3'b100, 32'h8C010074, c0 + 9});
        sb.push_back('{3'b001, 32'h8C010054, c0 + 14});
        sb.push_back('{3'b100, 32'h8C010074, c0 + 19});
        wait_to(c0 + 19);
        req = 3'b000;
        wait_to(c0 + 20);
        check("t3_drained", 32'(sb.size()), 32'h0);

        // write by requester 1, fields changed after grant
        do_reset();
        @(negedge clk);
        c0 = cyc;
        we = 3'b010; addr1 = 32'h100; wdata1 = 32'hDEADBEEF; be1 = 4'b0011; req = 3'b010;
        sb.push_back('{3'b010, 32'h0, c0 + 4});
        wait_to(c0 + 1);
        check("t4_mem_en", 32'(mem_en), 32'h1);
        check("t4_mem_we", 32'(mem_we), 32'h1);
        check("t4_mem_be", 32'(mem_be), 32'h3);
        check("t4_mem_wdata", mem_wdata, 32'hDEADBEEF);
        wait_to(c0 + 2);
        wdata1 = 32'h12345678; be1 = 4'b1111; addr1 = 32'h200; we = 3'b000;
        wait_to(c0 + 3);
        check("t4_wdata_held", mem_wdata, 32'hDEADBEEF);
        check("t4_be_held", 32'(mem_be), 32'h3);
        check("t4_addr_held", mem_addr, 32'h100);
        check("t4_we_held", 32'(mem_we), 32'h1);
        wait_to(c0 + 4);
        req = 3'b000;
        wait_to(c0 + 5);
        check("t4_drained", 32'(sb.size()), 32'h0);

        // reset in the middle of a read, then ptr must be back at 2
        do_reset();
        @(negedge clk);
        c0 = cyc;
        we = 3'b000; addr0 = 32'h80; req = 3'b001;
        wait_to(c0 + 2);
        check("t5_gnt_before", 32'(gnt), 32'h1);
        rst = 1'b1;
        #1;
        check("t5_rst_gnt", 32'(gnt), 32'h0);
        check("t5_rst_mem_en", 32'(mem_en), 32'h0);
        check("t5_rst_ack", 32'(ack), 32'h0);
        check("t5_rst_mem_addr", mem_addr, 32'h0);
        req = 3'b011;
        wait_to(c0 + 3);
        rst = 1'b0;
        sb.push_back('{3'b001, 32'h8C0100C4, c0 + 7});
        sb.push_back('{3'b010, 32'h8C010244, c0 + 12});
        wait_to(c0 + 4);
        check("t5_reissue_en", 32'(mem_en), 32'h1);
        check("t5_reissue_gnt", 32'(gnt), 32'h1);
        check("t5_reissue_addr", mem_addr, 32'h80);
        wait_to(c0 + 7);
        req = 3'b010;
        wait_to(c0 + 12);
        req = 3'b000;
        wait_to(c0 + 13);
        check("t5_drained", 32'(sb.size()), 32'h0);

        // req0 pulsed while requester 1 is served: never granted
        @(negedge clk);
        c0 = cyc;
        we = 3'b000; addr1 = 32'h200; req = 3'b010;
        sb.push_back('{3'b010, 32'h8C010244, c0 + 4});
        wait_to(c0 + 2);
        req = 3'b011;
        wait_to(c0 + 3);
        req = 3'b010;
        wait_to(c0 + 4);
        req = 3'b000;
        wait_to(c0 + 6);
        check("t6_gnt_idle", 32'(gnt), 32'h0);
        check("t6_mem_en_idle", 32'(mem_en), 32'h0);
        wait_to(c0 + 10);
        check("t6_no_late_en", 32'(mem_en), 32'h0);
        check("t6_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
